// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU widths, opcode constants, command struct and a
//               reference evaluation function for the 8-bit ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int c_DATA_W = 8;
    localparam int c_OP_W   = 3;

    localparam logic [c_OP_W-1:0] c_OP_ADD = 3'd0;
    localparam logic [c_OP_W-1:0] c_OP_SUB = 3'd1;
    localparam logic [c_OP_W-1:0] c_OP_SHL = 3'd2;
    localparam logic [c_OP_W-1:0] c_OP_SHR = 3'd3;
    localparam logic [c_OP_W-1:0] c_OP_AND = 3'd4;
    localparam logic [c_OP_W-1:0] c_OP_OR  = 3'd5;
    localparam logic [c_OP_W-1:0] c_OP_XOR = 3'd6;
    localparam logic [c_OP_W-1:0] c_OP_EQ  = 3'd7;

    typedef struct packed {
        logic [c_DATA_W-1:0] a;
        logic [c_DATA_W-1:0] b;
        logic [c_OP_W-1:0]   op;
    } cmd_t;

    // Shift amount uses only the low bits of operand B.
    function automatic logic [c_DATA_W-1:0] alu_eval(
        input logic [c_DATA_W-1:0] a,
        input logic [c_DATA_W-1:0] b,
        input logic [c_OP_W-1:0]   op
    );
        logic [c_DATA_W-1:0] r;
        case (op)
            c_OP_ADD: r = a + b;
            c_OP_SUB: r = a - b;
            c_OP_SHL: r = a << b[$clog2(c_DATA_W)-1:0];
            c_OP_SHR: r = a >> b[$clog2(c_DATA_W)-1:0];
            c_OP_AND: r = a & b;
            c_OP_OR:  r = a | b;
            c_OP_XOR: r = a ^ b;
            default:  r = {{(c_DATA_W-1){1'b0}}, (a == b)};
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_fifo
// Description : Synchronous FIFO with occupancy count; head reads as zero
//               while empty. DEPTH must be a power of two >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push = i_push && (r_count < c_CNT_W'(DEPTH));
    assign w_pop  = i_pop && (r_count != '0);

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : Queues ALU commands, drives the queue head to the external
//               ALU and captures its result with a valid/ready output.
//               Define ALU_ISSUE_ZERO_FLAG_EN to add the zero_o flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = c_DATA_W,
    parameter int OP_W   = c_OP_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [DATA_W-1:0]      cmd_a_i,
    input  logic [DATA_W-1:0]      cmd_b_i,
    input  logic [OP_W-1:0]        cmd_op_i,
    output logic [DATA_W-1:0]      alu_a_o,
    output logic [DATA_W-1:0]      alu_b_o,
    output logic [OP_W-1:0]        alu_op_o,
    input  logic [DATA_W-1:0]      alu_res_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [DATA_W-1:0]      res_data_o,
    output logic [OP_W-1:0]        res_op_o,
    output logic [$clog2(DEPTH):0] count_o
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    ,
    output logic                   zero_o
`endif
);

    localparam int c_CNT_W   = $clog2(DEPTH) + 1;
    localparam int c_ENTRY_W = 2 * DATA_W + OP_W;

    localparam logic [0:0] c_RES_EMPTY = 1'b0;
    localparam logic [0:0] c_RES_FULL  = 1'b1;

    logic [0:0]           r_res_state;
    logic [DATA_W-1:0]    r_res_data;
    logic [OP_W-1:0]      r_res_op;
    logic [c_CNT_W-1:0]   w_count;
    logic [c_ENTRY_W-1:0] w_head;
    logic                 w_cmd_ready;
    logic                 w_push;
    logic                 w_issue;
    logic                 w_res_valid;

    assign w_res_valid = (r_res_state == c_RES_FULL);
    // Readiness looks only at registered occupancy, never at a same-cycle pop.
    assign w_cmd_ready = (w_count < c_CNT_W'(DEPTH));
    assign w_push      = cmd_valid_i && w_cmd_ready;
    assign w_issue     = (w_count != '0) && (!w_res_valid || res_ready_i);

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_cmd_fifo (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_push      (w_push),
        .i_push_data ({cmd_a_i, cmd_b_i, cmd_op_i}),
        .i_pop       (w_issue),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign {alu_a_o, alu_b_o, alu_op_o} = w_head;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_res_state <= c_RES_EMPTY;
            r_res_data  <= '0;
            r_res_op    <= '0;
        end else if (w_issue) begin
            r_res_state <= c_RES_FULL;
            r_res_data  <= alu_res_i;
            r_res_op    <= alu_op_o;
        end else if (w_res_valid && res_ready_i) begin
            r_res_state <= c_RES_EMPTY;
        end
    end

`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic r_zero;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_zero <= 1'b0;
        end else if (w_issue) begin
            r_zero <= (alu_res_i == '0);
        end
    end

    assign zero_o = r_zero;
`endif

    assign cmd_ready_o = w_cmd_ready;
    assign res_valid_o = w_res_valid;
    assign res_data_o  = r_res_data;
    assign res_op_o    = r_res_op;
    assign count_o     = w_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Directed self-checking bench for alu_issue_stage, DEPTH=4,
//               with the reference ALU evaluated combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;
    import alu_pkg::*;

    localparam int c_DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [2:0] cmd_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_res;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [2:0] res_op;
    logic [2:0] count;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic       zero;
`endif

    int n_checks = 0;
    int n_errors = 0;

    alu_issue_stage #(
        .DEPTH  (c_DEPTH),
        .DATA_W (8),
        .OP_W   (3)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_a_i     (cmd_a),
        .cmd_b_i     (cmd_b),
        .cmd_op_i    (cmd_op),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_op_o    (alu_op),
        .alu_res_i   (alu_res),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_data_o  (res_data),
        .res_op_o    (res_op),
        .count_o     (count)
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        ,
        .zero_o      (zero)
`endif
    );

    always_comb alu_res = alu_eval(alu_a, alu_b, alu_op);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input cmd_t c);
        cmd_valid = 1'b1;
        cmd_a     = c.a;
        cmd_b     = c.b;
        cmd_op    = c.op;
    endtask

    cmd_t burst [6];
    logic [7:0] burst_res [6];

    initial begin
        burst[0] = '{a: 8'h01, b: 8'h02, op: c_OP_ADD}; burst_res[0] = 8'h03;
        burst[1] = '{a: 8'h09, b: 8'h04, op: c_OP_SUB}; burst_res[1] = 8'h05;
        burst[2] = '{a: 8'hF0, b: 8'h3C, op: c_OP_AND}; burst_res[2] = 8'h30;
        burst[3] = '{a: 8'h0F, b: 8'h30, op: c_OP_OR};  burst_res[3] = 8'h3F;
        burst[4] = '{a: 8'hFF, b: 8'h0F, op: c_OP_XOR}; burst_res[4] = 8'hF0;
        burst[5] = '{a: 8'h80, b: 8'h03, op: c_OP_SHR}; burst_res[5] = 8'h10;

        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; res_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(res_valid), 0);
        check("rst_data", 32'(res_data), 0);
        check("rst_op", 32'(res_op), 0);
        check("rst_alu", 32'({alu_a, alu_b, alu_op}), 0);
        check("rst_ready", 32'(cmd_ready), 1);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        check("rst_zero", 32'(zero), 0);
`endif

        // Single command: accepted at one edge, result visible after the next.
        res_ready = 1'b1;
        drive('{a: 8'h0F, b: 8'h01, op: c_OP_ADD});
        step();
        cmd_valid = 1'b0;
        check("one_count", 32'(count), 1);
        check("one_valid_early", 32'(res_valid), 0);
        check("one_head_a", 32'(alu_a), 'h0F);
        step();
        check("one_valid", 32'(res_valid), 1);
        check("one_data", 32'(res_data), 'h10);
        check("one_op", 32'(res_op), 0);
        check("one_count_after", 32'(count), 0);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        check("one_zero", 32'(zero), 0);
`endif
        step();
        check("one_drained", 32'(res_valid), 0);

        // Backpressure: five commands fill the result register and the FIFO.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(burst[i]);
            check($sformatf("bp_ready_%0d", i), 32'(cmd_ready), 1);
            step();
        end
        drive(burst[5]);
        check("bp_count_full", 32'(count), 4);
        check("bp_ready_full", 32'(cmd_ready), 0);
        check("bp_data0", 32'(res_data), 'h03);
        check("bp_valid", 32'(res_valid), 1);
        step();
        check("bp_sixth_rejected", 32'(count), 4);
        check("bp_data_hold", 32'(res_data), 'h03);
        check("bp_op_hold", 32'(res_op), 32'(c_OP_ADD));
        check("bp_head_a", 32'(alu_a), 'h09);

        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            step();
            check($sformatf("drain_data_%0d", i), 32'(res_data), 32'(burst_res[i]));
            check($sformatf("drain_op_%0d", i), 32'(res_op), 32'(burst[i].op));
            check($sformatf("drain_count_%0d", i), 32'(count), 32'(4 - i));
            check($sformatf("drain_ready_%0d", i), 32'(cmd_ready), 1);
        end
        step();
        check("drain_empty", 32'(res_valid), 0);

        // Streaming push and drain every cycle.
        drive('{a: 8'h05, b: 8'h07, op: c_OP_SUB});
        step();
        check("st_count0", 32'(count), 1);
        drive('{a: 8'h55, b: 8'h55, op: c_OP_EQ});
        step();
        check("st_res_sub", 32'(res_data), 'hFE);
        check("st_count1", 32'(count), 1);
        drive('{a: 8'h81, b: 8'h09, op: c_OP_SHL});
        step();
        check("st_res_eq", 32'(res_data), 'h01);
        check("st_count2", 32'(count), 1);
        cmd_valid = 1'b0;
        step();
        check("st_res_shl", 32'(res_data), 'h02);
        check("st_valid", 32'(res_valid), 1);
        check("st_count3", 32'(count), 0);
        step();

        // Zero result.
        drive('{a: 8'hA5, b: 8'hA5, op: c_OP_XOR});
        step();
        cmd_valid = 1'b0;
        step();
        check("xor_data", 32'(res_data), 0);
        check("xor_op", 32'(res_op), 32'(c_OP_XOR));
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        check("xor_zero", 32'(zero), 1);
`endif
        step();

        // Reset with three queued commands and one pending result.
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(burst[i]);
            step();
        end
        cmd_valid = 1'b0;
        check("pre_rst_count", 32'(count), 3);
        check("pre_rst_valid", 32'(res_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_valid", 32'(res_valid), 0);
        check("mid_rst_alu", 32'({alu_a, alu_b, alu_op}), 0);
        check("mid_rst_data", 32'(res_data), 0);
        check("mid_rst_ready", 32'(cmd_ready), 1);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        check("mid_rst_zero", 32'(zero), 0);
`endif
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("no_stale_%0d", i), 32'(res_valid), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
# alu_issue_stage

Command-buffering issue stage that sits directly upstream of the 8-bit combinational ALU. It accepts operand/opcode commands over a valid/ready handshake and queues them in a small FIFO. It drives the queue head onto the ALU input ports, then captures the ALU result into a registered output with its own valid/ready handshake. It decouples the command producer from the result consumer and sustains one operation per cycle.

## Interface
Parameters:
- `DEPTH`, 4, command FIFO entries; power of two, ≥ 2
- `DATA_W`, 8, operand/result width
- `OP_W`, 3, opcode width

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `cmd_valid_i`  in  1  command present
- `cmd_ready_o`  out  1  FIFO can accept a command
- `cmd_a_i`  in  DATA_W  operand A
- `cmd_b_i`  in  DATA_W  operand B
- `cmd_op_i`  in  OP_W  opcode
- `alu_a_o`  out  DATA_W  FIFO head operand A to ALU
- `alu_b_o`  out  DATA_W  FIFO head operand B to ALU
- `alu_op_o`  out  OP_W  FIFO head opcode to ALU
- `alu_res_i`  in  DATA_W  ALU combinational result
- `res_valid_o`  out  1  result register holds a result
- `res_ready_i`  in  1  consumer takes the result
- `res_data_o`  out  DATA_W  captured result
- `res_op_o`  out  OP_W  opcode that produced `res_data_o`
- `count_o`  out  $clog2(DEPTH)+1  FIFO occupancy
- `zero_o`  out  1  present only with `ALU_ISSUE_ZERO_FLAG_EN`

## Operation
- Push: `cmd_valid_i && cmd_ready_o` writes {a,b,op} at the write pointer. `cmd_ready_o = (count_o < DEPTH)`; it depends on registered occupancy only, not on a same-cycle pop.
- ALU drive: when the FIFO is non-empty, `alu_*_o` show the head entry. When empty, they are all-zero.
- Output register has two states, EMPTY (`res_valid_o=0`) and FULL (`res_valid_o=1`).
- Issue condition: `issue = (count_o != 0) && (!res_valid_o || res_ready_i)`.
- On issue: pop the head; load `res_data_o <= alu_res_i`, `res_op_o <= alu_op_o`, `res_valid_o <= 1`.
- No issue, but `res_valid_o && res_ready_i`: set `res_valid_o <= 0`. Data fields hold their last value.
- FULL and `!res_ready_i`: `res_data_o` and `res_op_o` are held stable.
- Push and pop in the same cycle: `count_o` is unchanged. Pointers wrap modulo DEPTH.
- Full FIFO: `cmd_ready_o=0`. A push is never accepted in a cycle where `count_o==DEPTH`, even if a pop occurs in that cycle.
- Result ordering is strictly FIFO order of acceptance.

## Timing
- Reset (`rst_i` high at edge): `count_o=0`, pointers 0, `res_valid_o=0`, `res_data_o=0`, `res_op_o=0`, `zero_o=0`. This makes `alu_*_o=0` and `cmd_ready_o=1`.
- Reset mid-operation discards all queued commands and any pending result. Storage RAM contents need not be cleared.
- Latency: a command accepted at edge k issues at edge k+1 at the earliest (no empty-FIFO bypass). `res_valid_o` is high from edge k+1.
- Throughput: one command per cycle when `res_ready_i` is held high.
- Max buffering: DEPTH commands plus 1 result.

## Configuration
- `ALU_ISSUE_ZERO_FLAG_EN` defined: adds port `zero_o`, registered alongside the result.
  - On issue: `zero_o <= (alu_res_i == 0)`.
  - Held with `res_data_o`; reset to 0.
- Undefined: port and register are absent. All other behaviour is identical.

## Structure
- Shared package `alu_pkg`: DATA_W/OP_W defaults, opcode constants (ADD=0, SUB=1, SHL=2, SHR=3, AND=4, OR=5, XOR=6, EQ=7), and packed command struct {a, b, op}.
- Sub-module `alu_cmd_fifo`: synchronous FIFO parameterized on DEPTH and entry width. It exposes push/pop/head/count.
- The top level holds issue logic and the result register. The ALU itself is instantiated outside, alongside this block.

## Test plan
Benches connect a real ALU instance, DEPTH=4.
- Reset, then push {0x0F,0x01,ADD} with `res_ready_i=1`: `res_valid_o` high one cycle after acceptance, `res_data_o=0x10`, `res_op_o=0`. With the macro, `zero_o=0`.
- `res_ready_i=0`; push 5 commands back-to-back: result register FULL with the first command, `count_o=4`, `cmd_ready_o=0`. The 6th `cmd_valid_i` is not accepted, and `res_data_o` stays stable.
- Then raise `res_ready_i` continuously: remaining 4 results appear on consecutive cycles in order, `count_o` goes 4→0, `cmd_ready_o` rises after the first pop.
- Streaming push and drain every cycle with SUB {0x05,0x07}, EQ {0x55,0x55}, SHL {0x81,0x09}: results 0xFE, 0x01, 0x02 in order; `count_o` stays ≤ 1.
- With the macro: XOR {0xA5,0xA5} → `res_data_o=0x00`, `zero_o=1`.
- With 3 queued and a pending result, assert `rst_i` for one cycle: next cycle `count_o=0`, `res_valid_o=0`, `alu_*_o=0`, and no stale result ever appears.
